// File: rtl/gf_red_pkg.sv
// Shared types and constants for the red_sched controller of the sequential
// GF(2^m) reduction unit.
package gf_red_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  localparam int GRADE_MIN = 2;

  // Cycles the unit may spend in a run before the controller gives up on it.
  function automatic int RED_TIMEOUT(input int data_width);
    return 2 * data_width + 4;
  endfunction

  function automatic int grade_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

endpackage

// File: rtl/red_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts just after the last granted requester
// and wraps; the pointer register itself lives in the parent.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic [IDW-1:0] pos;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    pos       = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant_idx  = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/red_sched.sv
// Arbitrates several requesters onto one sequential reduction unit, drives its
// op_enable protocol with a watchdog and returns tagged results.
module red_sched
  import gf_red_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int NUM_REQ    = 2,
  localparam int GW         = grade_width(DATA_WIDTH),
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*GW-1:0]           req_grade,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_polyn,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_operand,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [IDW-1:0]                  resp_id,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            resp_err,
  output logic                            red_op_enable,
  output logic [GW-1:0]                   red_polyn_grade,
  output logic [DATA_WIDTH:0]             red_polyn_red_in,
  output logic [2*DATA_WIDTH-1:0]         red_reduc_in,
  input  logic [DATA_WIDTH-1:0]           red_out,
  input  logic                            red_op_finish
);

  localparam int TIMEOUT = RED_TIMEOUT(DATA_WIDTH);
  localparam int WDW     = $clog2(TIMEOUT + 1);

  state_t                  state;
  logic [IDW-1:0]          last_grant;
  logic [WDW-1:0]          wdog;
  logic [GW-1:0]           hold_grade;
  logic [DATA_WIDTH:0]     hold_polyn;
  logic [2*DATA_WIDTH-1:0] hold_operand;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDW-1:0]          arb_idx;
  logic [GW-1:0]           sel_grade;
  logic [DATA_WIDTH:0]     sel_polyn;
  logic [2*DATA_WIDTH-1:0] sel_operand;
  logic                    grade_ok;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    sel_grade   = '0;
    sel_polyn   = '0;
    sel_operand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_grade   = req_grade[i*GW +: GW];
        sel_polyn   = req_polyn[i*(DATA_WIDTH+1) +: DATA_WIDTH+1];
        sel_operand = req_operand[i*2*DATA_WIDTH +: 2*DATA_WIDTH];
      end
    end
  end

  assign grade_ok = (int'(sel_grade) >= GRADE_MIN) && (int'(sel_grade) <= DATA_WIDTH);

  // Accept is only offered while idle and out of reset, so it is one-hot or zero.
  assign req_ready = (state == IDLE && !rst) ? arb_grant : '0;

  assign red_polyn_grade  = hold_grade;
  assign red_polyn_red_in = hold_polyn;
  assign red_reduc_in     = hold_operand;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= IDW'(NUM_REQ - 1);
      wdog          <= '0;
      hold_grade    <= '0;
      hold_polyn    <= '0;
      hold_operand  <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      red_op_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            hold_grade   <= sel_grade;
            hold_polyn   <= sel_polyn;
            hold_operand <= sel_operand;
            resp_id      <= arb_idx;
            last_grant   <= arb_idx;
            wdog         <= '0;
            if (grade_ok) begin
              state         <= RUN;
              red_op_enable <= 1'b1;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end
          end
        end
        RUN: begin
          if (red_op_finish) begin
            state         <= RESP;
            red_op_enable <= 1'b0;
            resp_valid    <= 1'b1;
            resp_data     <= red_out;
            resp_err      <= 1'b0;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            // Last permitted run cycle without a finish: abandon the operation.
            state         <= RESP;
            red_op_enable <= 1'b0;
            resp_valid    <= 1'b1;
            resp_data     <= '0;
            resp_err      <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
